// File: rtl/seq_101_pkg.sv
// Shared definitions for the 101-preamble serial transmitter and its detector bench.
// Define SEQ_TX_PARITY_EN to add the PAR state to the shared encoding.
package seq_101_pkg;

    localparam logic [2:0] PREAMBLE     = 3'b101;
    localparam int         PREAMBLE_LEN = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE_A = 3'd1,
        PRE_B = 3'd2,
        PRE_C = 3'd3,
`ifdef SEQ_TX_PARITY_EN
        DATA  = 3'd4,
        PAR   = 3'd5
`else
        DATA  = 3'd4
`endif
    } tx_state_t;

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register with a remaining-bit counter and a last-bit flag.
module seq_tx_shreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         msb_o,
    output logic         last_o
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = din_i;
            cnt_d = CNT_W'(W);
        end else if (shift_i && (cnt_q != '0)) begin
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts bits still to send, so the current MSB is the last one when it reaches 1.
    assign msb_o  = sh_q[W-1];
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seq_tx_101.sv
// Moore-FSM serial framer: preamble 1,0,1 then PAYLOAD_W bits MSB-first on D.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_tx_101
    import seq_101_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 D,
    output logic                 busy,
    output logic                 done,
    output tx_state_t            dbg_state
);

    tx_state_t state_q, state_d;
    logic      handshake;
    logic      sh_msb;
    logic      sh_last;

    // A word transfers when valid && ready at a rising edge; ready is high only in IDLE,
    // so valid outside IDLE is ignored and data is sampled exactly once per frame.
    assign handshake = valid && (state_q == IDLE);

    seq_tx_shreg #(
        .W (PAYLOAD_W)
    ) u_shreg (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (handshake),
        .shift_i (state_q == DATA),
        .din_i   (data),
        .msb_o   (sh_msb),
        .last_o  (sh_last)
    );

`ifdef SEQ_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (handshake) begin
            par_q <= ^data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (valid) state_d = PRE_A;
            PRE_A: state_d = PRE_B;
            PRE_B: state_d = PRE_C;
            PRE_C: state_d = DATA;
`ifdef SEQ_TX_PARITY_EN
            DATA:  if (sh_last) state_d = PAR;
            PAR:   state_d = IDLE;
`else
            DATA:  if (sh_last) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on state and registered shift-register bits only.
    always_comb begin
        D     = 1'b0;
        ready = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            PRE_A: D = PREAMBLE[2];
            PRE_B: D = PREAMBLE[1];
            PRE_C: D = PREAMBLE[0];
            DATA: begin
                D = sh_msb;
`ifdef SEQ_TX_PARITY_EN
                done = 1'b0;
`else
                done = sh_last;
`endif
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                D    = par_q;
                done = 1'b1;
            end
`endif
            default: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_tx_101.sv
// Directed bench for seq_tx_101 with a behavioural 101 detector on the D line.
// Honours SEQ_TX_PARITY_EN to select the expected frame length and parity bits.
module tb_seq_tx_101;
    import seq_101_pkg::*;

`ifdef SEQ_TX_PARITY_EN
    localparam int FRAME_LEN = 12;
    localparam logic [15:0] F_5A = 16'b0000_1010_1011_0100;
    localparam logic [15:0] F_A5 = 16'b0000_1011_0100_1010;
    localparam logic [15:0] F_07 = 16'b0000_1010_0000_1111;
    localparam logic [15:0] F_FF = 16'b0000_1011_1111_1110;
    localparam logic [15:0] F_00 = 16'b0000_1010_0000_0000;
    localparam logic [15:0] F_AA = 16'b0000_1011_0101_0100;
`else
    localparam int FRAME_LEN = 11;
    localparam logic [15:0] F_5A = 16'b0000_0101_0101_1010;
    localparam logic [15:0] F_A5 = 16'b0000_0101_1010_0101;
    localparam logic [15:0] F_07 = 16'b0000_0101_0000_0111;
    localparam logic [15:0] F_FF = 16'b0000_0101_1111_1111;
    localparam logic [15:0] F_00 = 16'b0000_0101_0000_0000;
    localparam logic [15:0] F_AA = 16'b0000_0101_1010_1010;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       D;
    logic       busy;
    logic       done;
    tx_state_t  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] det_hist;
    logic       det_q;

    seq_tx_101 #(
        .PAYLOAD_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .D         (D),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Moore 101 detector: Q is high the cycle after the third bit of the pattern is sampled.
    always @(posedge clk) begin
        if (rst) det_hist <= 3'b000;
        else     det_hist <= {det_hist[1:0], D};
    end
    assign det_q = (det_hist == 3'b101);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " D"},     32'(D),     32'd0);
        check({tag, " ready"}, 32'(ready), 32'd1);
        check({tag, " busy"},  32'(busy),  32'd0);
        check({tag, " done"},  32'(done),  32'd0);
    endtask

    // Checks n cycles of a frame starting at the currently visible cycle, stepping after each.
    task automatic check_bits(input string tag, input logic [15:0] bits, input int n,
                              input bit chk_det);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s D bit %0d", tag, i), 32'(D), 32'(bits[FRAME_LEN-1-i]));
            check($sformatf("%s busy %0d", tag, i), 32'(busy), 32'd1);
            check($sformatf("%s ready %0d", tag, i), 32'(ready), 32'd0);
            check($sformatf("%s done %0d", tag, i), 32'(done), 32'(i == FRAME_LEN - 1));
            if (chk_det && i == PREAMBLE_LEN)
                check($sformatf("%s detector Q", tag), 32'(det_q), 32'd1);
            step();
        end
    endtask

    function automatic logic [15:0] frame_of(input logic [7:0] d);
`ifdef SEQ_TX_PARITY_EN
        return {4'b0000, 3'b101, d, ^d};
`else
        return {5'b00000, 3'b101, d};
`endif
    endfunction

    initial begin
        logic [7:0] rd;

        // Reset held two cycles with valid high: no frame may start.
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'h5A;
        step();
        check_idle("rst edge 1");
        step();
        check_idle("rst edge 2");
        rst = 1'b0;
        step();
        valid = 1'b0;
        check_bits("post_rst 5A", F_5A, FRAME_LEN, 1'b0);
        check_idle("idle after 5A");
        step();

        // Single frame A5, data changed mid-frame.
        data  = 8'hA5;
        valid = 1'b1;
        step();
        valid = 1'b0;
        data  = 8'h00;
        check_bits("frame A5", F_A5, FRAME_LEN, 1'b0);
        check_idle("idle after A5");
        step();

        // Frame 07 (parity bit 1 when parity is built in).
        data  = 8'h07;
        valid = 1'b1;
        step();
        valid = 1'b0;
        check_bits("frame 07", F_07, FRAME_LEN, 1'b0);
        check_idle("idle after 07");
        step();

        // Back-to-back with valid held: exactly one IDLE cycle between frames.
        data  = 8'hFF;
        valid = 1'b1;
        step();
        data = 8'h00;
        check_bits("b2b FF", F_FF, FRAME_LEN, 1'b0);
        check_idle("b2b gap");
        step();
        valid = 1'b0;
        check_bits("b2b 00", F_00, FRAME_LEN, 1'b0);
        check_idle("idle after b2b");
        step();

        // Reset while payload bit 3 is on the line, with a handshake offered in the same cycle.
        data  = 8'hFF;
        valid = 1'b1;
        step();
        valid = 1'b0;
        check_bits("abort FF", F_FF, PREAMBLE_LEN + 3, 1'b0);
        check("abort bit3 D", 32'(D), 32'd1);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hAA;
        step();
        rst = 1'b0;
        check_idle("after abort");
        step();
        valid = 1'b0;
        check_bits("restart AA", F_AA, FRAME_LEN, 1'b0);
        check_idle("idle after AA");
        step();

        // Loopback into the detector with random payloads.
        for (int f = 0; f < 20; f++) begin
            rd    = 8'($urandom_range(0, 255));
            data  = rd;
            valid = 1'b1;
            step();
            valid = 1'b0;
            check_bits($sformatf("loop %0d", f), frame_of(rd), FRAME_LEN, 1'b1);
            check_idle($sformatf("loop idle %0d", f));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
